// File: rtl/md5_search_sched.sv
// md5_search_sched: issues one candidate per clock from a configured range into a
// 64-stage pipelined md5core, tracks in-flight candidates with a valid shift register,
// and compares each retired hash against a target.
// Optional feature macro: MD5_SCHED_MULTI_HIT_EN (keep running and count every match).
module md5_search_sched #(
  parameter  int unsigned PIPE_LAT  = 66,
  parameter  int unsigned CNT_W     = 64,
  localparam int unsigned LEN_W     = 7,
  localparam int unsigned HASH_W    = 128,
  localparam int unsigned HIT_W     = 16,
  localparam int unsigned LEN_OUT_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic [CNT_W-1:0]     cfg_first,
  input  logic [CNT_W-1:0]     cfg_last,
  input  logic [HASH_W-1:0]    cfg_target,
  output logic [CNT_W-1:0]     core_message,
  output logic [LEN_OUT_W-1:0] core_length,
  input  logic [HASH_W-1:0]    core_hash,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic [CNT_W-1:0]     found_msg,
  output logic [HIT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     issued
);

  localparam int unsigned CNT_X_W = CNT_W + 1;

`ifdef MD5_SCHED_MULTI_HIT_EN
  localparam bit MULTI_HIT = 1'b1;
`else
  localparam bit MULTI_HIT = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t              state_q, state_nx;
  logic [CNT_X_W-1:0]  next_cand_q;   // extra bit so the top of the range never wraps
  logic [CNT_W-1:0]    last_q;
  logic [CNT_W-1:0]    retire_q;
  logic [HASH_W-1:0]   target_q;
  logic                msg_vld_q;     // valid flag aligned with the core_message register
  logic [PIPE_LAT-1:0] valid_sr_q;

  logic [CNT_X_W-1:0]  len_mask_c;
  logic [CNT_W-1:0]    last_eff_c;
  logic                cfg_ok_c;
  logic                match_c;
  logic                record_c;
  logic                stop_c;
  logic                drain_empty_c;
  logic                issue_c;

  // Job legality, clamped range end and retirement qualification
  always_comb begin
    len_mask_c    = (CNT_X_W'(1) << cfg_len) - CNT_X_W'(1);
    last_eff_c    = (cfg_last < len_mask_c[CNT_W-1:0]) ? cfg_last : len_mask_c[CNT_W-1:0];
    cfg_ok_c      = (cfg_len != '0) && (cfg_len <= LEN_W'(CNT_W)) && (cfg_first <= last_eff_c);
    match_c       = valid_sr_q[PIPE_LAT-1] && (core_hash == target_q);
    record_c      = match_c && (MULTI_HIT || !found);
    stop_c        = abort || (match_c && !MULTI_HIT);
    // Leave DRAIN on the edge that shifts the final valid bit out of the tail
    drain_empty_c = (valid_sr_q[PIPE_LAT-2:0] == '0) && !msg_vld_q;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nx;
  end

  // Next-state and issue decision
  always_comb begin
    state_nx = state_q;
    issue_c  = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_nx = cfg_ok_c ? ST_RUN : ST_DONE;
      ST_RUN: begin
        if (stop_c) begin
          state_nx = ST_DRAIN;
        end else begin
          issue_c = 1'b1;
          if (next_cand_q == {1'b0, last_q}) state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: if (drain_empty_c) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Job configuration, issue stream, retirement tracking and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_cand_q  <= '0;
      last_q       <= '0;
      retire_q     <= '0;
      target_q     <= '0;
      msg_vld_q    <= 1'b0;
      valid_sr_q   <= '0;
      core_message <= '0;
      core_length  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      found        <= 1'b0;
      found_msg    <= '0;
      hit_count    <= '0;
      issued       <= '0;
    end else begin
      msg_vld_q  <= issue_c;
      valid_sr_q <= {valid_sr_q[PIPE_LAT-2:0], msg_vld_q};
      busy       <= (state_nx == ST_RUN) || (state_nx == ST_DRAIN);
      done       <= (state_nx == ST_DONE);
      if (state_q == ST_IDLE && start) begin
        next_cand_q <= {1'b0, cfg_first};
        last_q      <= last_eff_c;
        retire_q    <= cfg_first;
        target_q    <= cfg_target;
        core_length <= LEN_OUT_W'(cfg_len);
        found       <= 1'b0;
        found_msg   <= '0;
        hit_count   <= '0;
        issued      <= '0;
      end else begin
        if (issue_c) begin
          core_message <= next_cand_q[CNT_W-1:0];
          next_cand_q  <= next_cand_q + CNT_X_W'(1);
          issued       <= issued + CNT_W'(1);
        end
        if (valid_sr_q[PIPE_LAT-1]) retire_q <= retire_q + CNT_W'(1);
        if (record_c) begin
          found     <= 1'b1;
          found_msg <= retire_q;
          if (hit_count != '1) hit_count <= hit_count + HIT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_md5_search_sched.sv
// tb_md5_search_sched: directed bench for md5_search_sched with a behavioural
// 66-register core model. The model hash is a simple injective stand-in for MD5
// (the scheduler only compares hashes), with an optional forced alias H(3)=H(1).
module tb_md5_search_sched;

  localparam int unsigned PIPE_LAT = 66;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [6:0]   cfg_len;
  logic [63:0]  cfg_first;
  logic [63:0]  cfg_last;
  logic [127:0] cfg_target;
  logic [63:0]  core_message;
  logic [63:0]  core_length;
  logic [127:0] core_hash;
  logic         busy;
  logic         done;
  logic         found;
  logic [63:0]  found_msg;
  logic [15:0]  hit_count;
  logic [63:0]  issued;

  bit           alias_en = 1'b0;
  int unsigned  checks   = 0;
  int unsigned  errors   = 0;
  int unsigned  cyc;
  logic [127:0] hpipe [PIPE_LAT];

  md5_search_sched #(.PIPE_LAT(PIPE_LAT), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_len(cfg_len), .cfg_first(cfg_first), .cfg_last(cfg_last), .cfg_target(cfg_target),
    .core_message(core_message), .core_length(core_length), .core_hash(core_hash),
    .busy(busy), .done(done), .found(found), .found_msg(found_msg),
    .hit_count(hit_count), .issued(issued)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] hmodel(input logic [63:0] m, input logic [63:0] len, input bit al);
    logic [63:0] mm;
    mm = (al && m == 64'd3) ? 64'd1 : m;
    return {mm ^ 64'hA5A5_5A5A_0F0F_F0F0, (mm * 64'h9E37_79B9_7F4A_7C15) + len};
  endfunction

  // Core model: 1 pad register + 64 rounds + 1 output register
  always @(posedge clk) begin
    hpipe[0] <= hmodel(core_message, core_length, alias_en);
    for (int i = 1; i < PIPE_LAT; i++) hpipe[i] <= hpipe[i-1];
  end
  assign core_hash = hpipe[PIPE_LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge (edge 0 of the job)
  task automatic start_job(input logic [6:0] len, input logic [63:0] first,
                           input logic [63:0] last, input logic [127:0] tgt);
    cfg_len = len; cfg_first = first; cfg_last = last; cfg_target = tgt;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Edges after the start edge until done is seen (bounded)
  task automatic wait_done(input int unsigned max_cyc, output int unsigned n);
    n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  128'(busy), 128'd0);
    chk({tag, "_done"},  128'(done), 128'd0);
    chk({tag, "_found"}, 128'(found), 128'd0);
    chk({tag, "_fmsg"},  128'(found_msg), 128'd0);
    chk({tag, "_hits"},  128'(hit_count), 128'd0);
    chk({tag, "_iss"},   128'(issued), 128'd0);
    chk({tag, "_msg"},   128'(core_message), 128'd0);
    chk({tag, "_len"},   128'(core_length), 128'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_len = '0; cfg_first = '0; cfg_last = '0; cfg_target = '0;
    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Hit at 0x2A: issued at edge 0x2B, recorded 67 edges later
    start_job(7'd8, 64'h0, 64'hFF, hmodel(64'h2A, 64'd8, 1'b0));
    chk("j1_busy", 128'(busy), 128'd1);
    wait_done(400, cyc);
`ifdef MD5_SCHED_MULTI_HIT_EN
    chk("j1_cyc", 128'(cyc), 128'd323);
    chk("j1_iss", 128'(issued), 128'd256);
`else
    chk("j1_cyc", 128'(cyc), 128'(2 * PIPE_LAT + 8'h2B + 1));
    chk("j1_iss", 128'(issued), 128'(8'h2B + PIPE_LAT));
`endif
    chk("j1_found", 128'(found), 128'd1);
    chk("j1_fmsg", 128'(found_msg), 128'h2A);
    chk("j1_hits", 128'(hit_count), 128'd1);
    tick();
    chk("j1_done_once", 128'(done), 128'd0);
    chk("j1_idle", 128'(busy), 128'd0);

    // No hit: 16 issued, done 16+66+1 edges after start
    start_job(7'd8, 64'h10, 64'h1F, hmodel(64'h80, 64'd8, 1'b0));
    wait_done(400, cyc);
    chk("j2_cyc", 128'(cyc), 128'd83);
    chk("j2_iss", 128'(issued), 128'd16);
    chk("j2_found", 128'(found), 128'd0);
    chk("j2_msg", 128'(core_message), 128'h1F);
    tick();

    // Range end clamped to 2^4-1
    start_job(7'd4, 64'h0, 64'hFF, hmodel(64'hFF, 64'd4, 1'b0));
    wait_done(400, cyc);
    chk("j3_cyc", 128'(cyc), 128'd83);
    chk("j3_iss", 128'(issued), 128'd16);
    chk("j3_found", 128'(found), 128'd0);
    chk("j3_msg", 128'(core_message), 128'hF);
    chk("j3_len", 128'(core_length), 128'd4);
    tick();

    // Illegal length: straight to DONE
    start_job(7'd0, 64'h0, 64'hFF, 128'h0);
    chk("j4_done", 128'(done), 128'd1);
    chk("j4_busy", 128'(busy), 128'd0);
    chk("j4_iss", 128'(issued), 128'd0);
    tick();
    chk("j4_done_once", 128'(done), 128'd0);

    // Empty range: straight to DONE
    start_job(7'd8, 64'h5, 64'h4, 128'h0);
    chk("j5_done", 128'(done), 128'd1);
    chk("j5_iss", 128'(issued), 128'd0);
    chk("j5_found", 128'(found), 128'd0);
    tick();

    // Top of the 64-bit space: must stop, not wrap
    start_job(7'd64, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 128'h0);
    wait_done(400, cyc);
    chk("j6_cyc", 128'(cyc), 128'd70);
    chk("j6_iss", 128'(issued), 128'd3);
    chk("j6_msg", 128'(core_message), 128'hFFFF_FFFF_FFFF_FFFF);
    chk("j6_found", 128'(found), 128'd0);
    tick();

    // Abort after 10 issues, then a start during DRAIN that must be ignored
    start_job(7'd16, 64'h0, 64'hFFFF, hmodel(64'h5000, 64'd16, 1'b0));
    for (int i = 0; i < 10; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("j7_busy", 128'(busy), 128'd1);
    chk("j7_iss", 128'(issued), 128'd10);
    start_job(7'd8, 64'h0, 64'h3, 128'h0);
    chk("j7_iss_kept", 128'(issued), 128'd10);
    chk("j7_len_kept", 128'(core_length), 128'd16);
    wait_done(400, cyc);
    chk("j7_done", 128'(done), 128'd1);
    chk("j7_iss_end", 128'(issued), 128'd10);
    chk("j7_msg", 128'(core_message), 128'd9);
    tick();
    chk("j7_done_once", 128'(done), 128'd0);
    chk("j7_idle", 128'(busy), 128'd0);

    // Reset mid-RUN clears everything, and no done pulse follows
    start_job(7'd8, 64'h0, 64'hFF, 128'h0);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < PIPE_LAT + 4; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) chk("midrst_quiet", {done, busy}, 128'd0);
    end
    chk("midrst_iss", 128'(issued), 128'd0);

    // Forced alias H(3)=H(1)
    alias_en = 1'b1;
    start_job(7'd2, 64'h0, 64'h3, hmodel(64'h1, 64'd2, 1'b0));
    wait_done(400, cyc);
    chk("j9_cyc", 128'(cyc), 128'd71);
    chk("j9_iss", 128'(issued), 128'd4);
    chk("j9_found", 128'(found), 128'd1);
`ifdef MD5_SCHED_MULTI_HIT_EN
    chk("j9_hits", 128'(hit_count), 128'd2);
    chk("j9_fmsg", 128'(found_msg), 128'd3);
`else
    chk("j9_hits", 128'(hit_count), 128'd1);
    chk("j9_fmsg", 128'(found_msg), 128'd1);
`endif
    alias_en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
